// File: rtl/mvm_pkg.sv
// Shared state encoding, default sizes and the saturating-add helper for the MVM engine.
// sat_add is only referenced when MVM_SATURATE_EN is defined.
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        COMPUTE,
        FLUSH,
        OUTPUT
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_MAC    = 8;
    localparam int DEFAULT_VEC_LEN    = 8;

    // Widest accumulator the clamp helper supports.
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic                 ovf;
        logic [SAT_MAX_W-1:0] sum;
    } sat_res_t;

    // Adds two w-bit values held in the low bits of a and b, clamping to the
    // w-bit unsigned or two's-complement range and flagging any clamp.
    function automatic sat_res_t sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          w,
        input logic                 is_signed
    );
        logic [SAT_MAX_W:0]   mask;
        logic [SAT_MAX_W:0]   s;
        logic [SAT_MAX_W-1:0] lmask;
        logic [SAT_MAX_W-1:0] smask;
        logic                 sa;
        logic                 sb;
        logic                 ss;
        sat_res_t             r;
        mask  = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
        lmask = mask[SAT_MAX_W-1:0];
        smask = lmask ^ (lmask >> 1);
        s     = ({1'b0, a} & mask) + ({1'b0, b} & mask);
        sa    = |(a & smask);
        sb    = |(b & smask);
        ss    = |(s[SAT_MAX_W-1:0] & smask);
        r.ovf = 1'b0;
        r.sum = s[SAT_MAX_W-1:0] & lmask;
        if (is_signed) begin
            if ((sa == sb) && (ss != sa)) begin
                r.ovf = 1'b1;
                r.sum = sa ? smask : (lmask >> 1);
            end
        end else if (s > mask) begin
            r.ovf = 1'b1;
            r.sum = lmask;
        end
        return r;
    endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One MAC lane: registered product stage followed by an accumulate stage.
// With MVM_SATURATE_EN defined the accumulate clamps and reports a sticky overflow.
module mvm_mac_lane import mvm_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = 3*DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_vld_p0,
    input  logic                  i_signed,
    input  logic [DATA_WIDTH-1:0] i_a_p0,
    input  logic [DATA_WIDTH-1:0] i_b_p0,
`ifdef MVM_SATURATE_EN
    output logic                  o_ovf,
`endif
    output logic [ACC_WIDTH-1:0]  o_acc
);

    localparam int PW = 2*DATA_WIDTH;

    logic signed [PW-1:0]        w_sprod_p0;
    logic        [PW-1:0]        w_uprod_p0;
    logic        [PW-1:0]        r_prod_p1;
    logic                        r_vld_p1;
    logic        [ACC_WIDTH-1:0] w_ext_p1;
    logic        [ACC_WIDTH-1:0] w_acc_next;
    logic        [ACC_WIDTH-1:0] r_acc;

    assign w_sprod_p0 = PW'($signed(i_a_p0)) * PW'($signed(i_b_p0));
    assign w_uprod_p0 = PW'(i_a_p0) * PW'(i_b_p0);

    // ---- p0 -> p1: product register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_prod_p1 <= '0;
        end else if (i_clr) begin
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= i_vld_p0;
            if (i_vld_p0) begin
                r_prod_p1 <= i_signed ? w_sprod_p0 : w_uprod_p0;
            end
        end
    end

    always_comb begin
        w_ext_p1 = ACC_WIDTH'(r_prod_p1);
        if (i_signed) begin
            w_ext_p1 = ACC_WIDTH'($signed(r_prod_p1));
        end
    end

`ifdef MVM_SATURATE_EN
    sat_res_t w_sat_p1;
    logic     r_ovf;

    assign w_sat_p1   = sat_add(SAT_MAX_W'(r_acc), SAT_MAX_W'(w_ext_p1), ACC_WIDTH, i_signed);
    assign w_acc_next = w_sat_p1.sum[ACC_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_ovf <= 1'b0;
        end else if (r_vld_p1 && w_sat_p1.ovf) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`else
    assign w_acc_next = r_acc + w_ext_p1;
`endif

    // ---- p1 -> acc: accumulate ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (r_vld_p1) begin
            r_acc <= w_acc_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mvm_stream_engine.sv
// Matrix-vector engine: load B, stream A columns into NUM_MAC lanes, drain results over valid/ready.
// Define MVM_SATURATE_EN for clamping accumulators and a live sticky ovf flag.
module mvm_stream_engine import mvm_pkg::*; #(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int NUM_MAC    = DEFAULT_NUM_MAC,
    parameter  int VEC_LEN    = DEFAULT_VEC_LEN,
    parameter  int ACC_WIDTH  = 3*DATA_WIDTH,
    localparam int IDX_W      = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          signed_mode,
    output logic                          busy,
    output logic                          done,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [DATA_WIDTH-1:0]         b_data,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [NUM_MAC*DATA_WIDTH-1:0] a_data,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [IDX_W-1:0]              res_idx,
    output logic [ACC_WIDTH-1:0]          res_data,
    input  logic [IDX_W-1:0]              rd_sel,
    output logic [ACC_WIDTH-1:0]          rd_data,
    output logic                          ovf
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_bcnt;
    logic [CNT_W-1:0]      r_acnt;
    logic [IDX_W-1:0]      r_ridx;
    logic                  r_smode;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_b [VEC_LEN];
    logic [ACC_WIDTH-1:0]  w_acc [NUM_MAC];
    logic [ACC_WIDTH-1:0]  r_rd_data;
    logic [DATA_WIDTH-1:0] w_b_cur_p0;

    logic w_b_ready;
    logic w_a_ready;
    logic w_res_valid;
    logic w_start_acc;
    logic w_b_hs;
    logic w_a_hs;
    logic w_res_hs;
    logic w_b_last;
    logic w_a_last;
    logic w_res_last;

    // Ready/valid come only from the registered state, never from the peer's valid.
    assign w_b_ready   = (r_state == LOAD_B);
    assign w_a_ready   = (r_state == COMPUTE);
    assign w_res_valid = (r_state == OUTPUT);

    assign w_start_acc = start && (r_state == IDLE);
    assign w_b_hs      = b_valid && w_b_ready;
    assign w_a_hs      = a_valid && w_a_ready;
    assign w_res_hs    = w_res_valid && res_ready;
    assign w_b_last    = w_b_hs && (r_bcnt == CNT_W'(VEC_LEN-1));
    assign w_a_last    = w_a_hs && (r_acnt == CNT_W'(VEC_LEN-1));
    assign w_res_last  = w_res_hs && (r_ridx == IDX_W'(NUM_MAC-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_start_acc) w_next_state = LOAD_B;
            LOAD_B:  if (w_b_last)    w_next_state = COMPUTE;
            COMPUTE: if (w_a_last)    w_next_state = FLUSH;
            FLUSH:                    w_next_state = OUTPUT;
            OUTPUT:  if (w_res_last)  w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_acnt  <= '0;
            r_ridx  <= '0;
            r_smode <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_res_last;
            if (w_start_acc) begin
                r_bcnt  <= '0;
                r_acnt  <= '0;
                r_ridx  <= '0;
                r_smode <= signed_mode;
            end else begin
                if (w_b_hs) begin
                    r_bcnt <= w_b_last ? '0 : r_bcnt + 1'b1;
                end
                if (w_a_hs) begin
                    r_acnt <= w_a_last ? '0 : r_acnt + 1'b1;
                end
                if (w_res_hs) begin
                    r_ridx <= w_res_last ? '0 : r_ridx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < VEC_LEN; k++) begin
                r_b[k] <= '0;
            end
        end else if (w_b_hs) begin
            r_b[r_bcnt] <= b_data;
        end
    end

    assign w_b_cur_p0 = r_b[r_acnt];

`ifdef MVM_SATURATE_EN
    logic [NUM_MAC-1:0] w_lane_ovf;
`endif

    for (genvar g = 0; g < NUM_MAC; g++) begin : g_lane
        mvm_mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_clr    (w_start_acc),
            .i_vld_p0 (w_a_hs),
            .i_signed (r_smode),
            .i_a_p0   (a_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .i_b_p0   (w_b_cur_p0),
`ifdef MVM_SATURATE_EN
            .o_ovf    (w_lane_ovf[g]),
`endif
            .o_acc    (w_acc[g])
        );
    end

`ifdef MVM_SATURATE_EN
    assign ovf = |w_lane_ovf;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= (int'(rd_sel) < NUM_MAC) ? w_acc[rd_sel] : '0;
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign b_ready   = w_b_ready;
    assign a_ready   = w_a_ready;
    assign res_valid = w_res_valid;
    assign res_idx   = r_ridx;
    assign res_data  = w_acc[r_ridx];
    assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_mvm_stream_engine.sv
// Randomized bench for mvm_stream_engine: a 24-bit and a 16-bit accumulator instance share stimulus
// and are checked against a plain-arithmetic dot-product model (clamping when MVM_SATURATE_EN is set).
module tb_mvm_stream_engine;

    localparam int DW   = 8;
    localparam int NM   = 8;
    localparam int VL   = 8;
    localparam int AW   = 24;
    localparam int AW16 = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start, signed_mode, b_valid, a_valid, res_ready;
    logic [DW-1:0] b_data;
    logic [NM*DW-1:0] a_data;
    logic [2:0]    rd_sel;

    logic          busy, done, b_ready, a_ready, res_valid, ovf;
    logic [2:0]    res_idx;
    logic [AW-1:0] res_data, rd_data;

    logic            busy_s, done_s, b_ready_s, a_ready_s, res_valid_s, ovf_s;
    logic [2:0]      res_idx_s;
    logic [AW16-1:0] res_data_s, rd_data_s;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ma [NM][VL];
    logic [DW-1:0] mb [VL];
    logic [63:0]   exp24 [NM];
    logic [63:0]   exp16 [NM];
    bit            exp_ovf24, exp_ovf16;
    logic [63:0]   got24 [NM];
    logic [63:0]   got16 [NM];
    int            exp_idx = 0;
    int            rcv_cnt = 0;

    always #5 clk = ~clk;

    mvm_stream_engine u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .busy(busy), .done(done),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
        .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf)
    );

    mvm_stream_engine #(.ACC_WIDTH(AW16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .busy(busy_s), .done(done_s),
        .b_valid(b_valid), .b_ready(b_ready_s), .b_data(b_data),
        .a_valid(a_valid), .a_ready(a_ready_s), .a_data(a_data),
        .res_valid(res_valid_s), .res_ready(res_ready), .res_idx(res_idx_s), .res_data(res_data_s),
        .rd_sel(rd_sel), .rd_data(rd_data_s), .ovf(ovf_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Row dot product A[row]*B, accumulated in column order, reduced to aw bits.
    function automatic logic [63:0] model_dot(input int row, input bit sm, input int aw, output bit o);
        longint acc, p, lo, hi;
        acc = 0;
        o   = 1'b0;
        if (sm) begin
            lo = -(longint'(1) <<< (aw-1));
            hi = (longint'(1) <<< (aw-1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) <<< aw) - 1;
        end
        for (int j = 0; j < VL; j++) begin
            if (sm) p = longint'($signed(ma[row][j])) * longint'($signed(mb[j]));
            else    p = longint'(ma[row][j]) * longint'(mb[j]);
            acc = acc + p;
`ifdef MVM_SATURATE_EN
            if (acc > hi) begin acc = hi; o = 1'b1; end
            else if (acc < lo) begin acc = lo; o = 1'b1; end
`endif
        end
        return 64'(acc) & ((64'd1 << aw) - 64'd1);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_idx = 0;
            rcv_cnt = 0;
        end else begin
            if (start && !busy) begin
                exp_idx = 0;
                rcv_cnt = 0;
            end
            if (res_valid) begin
                if (exp_idx >= NM) begin
                    check("extra_result", 64'(exp_idx), 64'(NM-1));
                end else begin
                    check("res_idx", 64'(res_idx), 64'(exp_idx));
                    check("res_data24", 64'(res_data), exp24[exp_idx]);
                    check("res_valid16", 64'(res_valid_s), 64'd1);
                    check("res_data16", 64'(res_data_s), exp16[exp_idx]);
                    if (res_ready) begin
                        got24[exp_idx] = 64'(res_data);
                        got16[exp_idx] = 64'(res_data_s);
                        exp_idx++;
                        rcv_cnt++;
                    end
                end
            end
        end
    end

    task automatic run_job(input bit sm, input bit gaps, input bit inj, input int abort_at);
        int j, guard;
        bit hs, injected, seen, o;
        exp_ovf24 = 1'b0;
        exp_ovf16 = 1'b0;
        for (int i = 0; i < NM; i++) begin
            exp24[i] = model_dot(i, sm, AW, o);   exp_ovf24 |= o;
            exp16[i] = model_dot(i, sm, AW16, o); exp_ovf16 |= o;
        end
        start = 1'b1;
        signed_mode = sm;
        @(posedge clk); #1;
        start = 1'b0;
        signed_mode = 1'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        check("ovf_cleared", 64'(ovf), 64'd0);
        check("ovf16_cleared", 64'(ovf_s), 64'd0);
        check("b_ready_load", 64'(b_ready), 64'd1);

        j = 0; guard = 0;
        while (j < VL && guard < 400) begin
            b_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            b_data  = b_valid ? mb[j] : 8'($urandom);
            hs = b_valid && b_ready;
            @(posedge clk); #1;
            guard++;
            if (hs) j++;
        end
        b_valid = 1'b0;
        check("b_beats", 64'(j), 64'(VL));
        check("b_ready_dropped", 64'(b_ready), 64'd0);
        check("rd_cleared", 64'(rd_data), 64'd0);

        j = 0; guard = 0; injected = 1'b0;
        while (j < VL && guard < 400) begin
            if (abort_at >= 0 && j == abort_at) break;
            a_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            for (int i = 0; i < NM; i++) a_data[i*DW +: DW] = a_valid ? ma[i][j] : 8'($urandom);
            start = inj && !injected && (j == 2);
            if (start) begin
                injected = 1'b1;
                signed_mode = ~sm;
            end
            hs = a_valid && a_ready;
            @(posedge clk); #1;
            guard++;
            start = 1'b0;
            if (hs) j++;
        end
        a_valid = 1'b0;

        if (abort_at >= 0) begin
            check("abort_in_compute", 64'(a_ready), 64'd1);
            #2 rst_n = 1'b0;
            #1;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_a_ready", 64'(a_ready), 64'd0);
            check("rst_b_ready", 64'(b_ready), 64'd0);
            check("rst_res_valid", 64'(res_valid), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_ovf", 64'(ovf), 64'd0);
            check("rst_res_idx", 64'(res_idx), 64'd0);
            check("rst_res_data", 64'(res_data), 64'd0);
            check("rst_rd_data", 64'(rd_data), 64'd0);
            check("rst_res_data16", 64'(res_data_s), 64'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            return;
        end

        check("a_beats", 64'(j), 64'(VL));
        check("flush_gap", 64'(res_valid), 64'd0);
        @(posedge clk); #1;
        check("res_valid_rise", 64'(res_valid), 64'd1);

        seen = 1'b0; guard = 0;
        while (!seen && guard < 400) begin
            res_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            guard++;
            if (done) begin
                seen = 1'b1;
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
        res_ready = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
        check("results_received", 64'(rcv_cnt), 64'(NM));
        check("ovf24", 64'(ovf), 64'(exp_ovf24));
        check("ovf16", 64'(ovf_s), 64'(exp_ovf16));
        @(posedge clk); #1;
        check("done_single", 64'(done), 64'd0);
        check("idle_after", 64'(busy), 64'd0);
        check("no_valid_after", 64'(res_valid), 64'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NM; i++)
            for (int j = 0; j < VL; j++)
                ma[i][j] = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
        for (int j = 0; j < VL; j++)
            mb[j] = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom);
    endtask

    initial begin
        start = 1'b0; signed_mode = 1'b0; b_valid = 1'b0; a_valid = 1'b0; res_ready = 1'b0;
        b_data = '0; a_data = '0; rd_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_b_ready", 64'(b_ready), 64'd0);
        check("reset_a_ready", 64'(a_ready), 64'd0);
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        check("reset_res_idx", 64'(res_idx), 64'd0);
        check("reset_res_data", 64'(res_data), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_ready", 64'(b_ready), 64'd0);

        // Ramp: A[i][j]=i+1, B[j]=j+1
        for (int i = 0; i < NM; i++)
            for (int j = 0; j < VL; j++) ma[i][j] = 8'(i + 1);
        for (int j = 0; j < VL; j++) mb[j] = 8'(j + 1);
        run_job(1'b0, 1'b0, 1'b0, -1);
        for (int i = 0; i < NM; i++) check("ramp_literal", got24[i], 64'(36 * (i + 1)));
        rd_sel = 3'd7;
        @(posedge clk); #1;
        check("rd_sel7", 64'(rd_data), 64'd288);
        rd_sel = 3'd3;
        @(posedge clk); #1;
        check("rd_sel3", 64'(rd_data), 64'd144);

        // -1 * 127 summed 8 times, then the same bytes read as unsigned
        for (int i = 0; i < NM; i++)
            for (int j = 0; j < VL; j++) ma[i][j] = 8'hFF;
        for (int j = 0; j < VL; j++) mb[j] = 8'h7F;
        run_job(1'b1, 1'b0, 1'b0, -1);
        for (int i = 0; i < NM; i++) check("signed_literal", got24[i], 64'h00FFFC08);
        run_job(1'b0, 1'b0, 1'b0, -1);
        for (int i = 0; i < NM; i++) check("unsigned_literal", got24[i], 64'h0003F408);

        // 255*255 summed 8 times overflows a 16-bit accumulator
        for (int j = 0; j < VL; j++) mb[j] = 8'hFF;
        run_job(1'b0, 1'b0, 1'b0, -1);
`ifdef MVM_SATURATE_EN
        check("acc16_literal", got16[0], 64'hFFFF);
        check("ovf16_literal", 64'(ovf_s), 64'd1);
`else
        check("acc16_literal", got16[0], 64'hF008);
        check("ovf16_literal", 64'(ovf_s), 64'd0);
`endif

        for (int t = 0; t < 6; t++) begin
            fill_random();
            rd_sel = 3'($urandom);
            run_job(1'($urandom), 1'b1, t[0], -1);
        end

        fill_random();
        run_job(1'b0, 1'b1, 1'b0, 3);
        fill_random();
        run_job(1'b1, 1'b1, 1'b0, -1);
        fill_random();
        run_job(1'b0, 1'b1, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
